es_hilo_muldiv: RTL and testbench
=================================

Name: es_hilo_muldiv

Overview:
- Multi-cycle multiply/divide unit with the architectural HI/LO registers, instantiated beside the execute stage.
- The execute stage presents decoded mult/multu/div/divu requests (one-hot op, rs/rt values) and mthi/mtlo writes.
- The unit iterates, writes HI/LO, and exposes HI/LO for mfhi/mflo.
- The execute stage stalls (es_allowin low) while md_ready is low.

Parameters:
- DIV_CYCLES, 32, number of restoring-division iterations (fixed to operand width; not otherwise supported).

Ports:
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- md_valid  in  1  request valid from execute stage.
- md_op  in  4  one-hot op: bit0 mult, bit1 multu, bit2 div, bit3 divu.
- md_src1  in  32  rs value (multiplicand / dividend).
- md_src2  in  32  rt value (multiplier / divisor).
- md_flush  in  1  cancel in-flight operation.
- mt_we  in  2  {hi_we, lo_we} from mthi/mtlo.
- mt_wdata  in  32  mthi/mtlo data.
- md_ready  out  1  unit idle, can accept a request.
- md_done  out  1  one-cycle pulse in the cycle HI/LO take a mul/div result.
- hi_rdata  out  32  current HI register.
- lo_rdata  out  32  current LO register.

Behaviour:
- Reset values: state IDLE, HI=0, LO=0, md_ready=1, md_done=0. Reset mid-operation aborts it, with no done pulse.
- States: IDLE, MUL, DIV, DONE.
- Accept condition: md_valid & md_ready & md_op one-hot.
  - md_op==0 or multi-hot: no-op, stays IDLE.
  - Operands and signedness are latched at accept.
  - md_ready drops the cycle after accept.
- MUL:
  - Entered on accept of mult/multu.
  - The 64-bit product (signed for mult, unsigned for multu) is registered in MUL.
  - Next edge: {HI,LO} <= product, go to DONE.
  - Latency: HI/LO updated on the 2nd rising edge after the accept edge.
- DIV:
  - Restoring division on |src1| and |src2| (plain values for divu), with a 6-bit iteration counter.
  - One quotient bit per cycle; after DIV_CYCLES iterations, go to DONE.
  - Sign fix-up on the final write: quotient negated if sign1^sign2; remainder takes sign1.
  - LO <= quotient, HI <= remainder.
  - Latency: HI/LO updated on the 33rd edge after accept.
  - Divide by zero is deterministic: quotient bits all 1 and remainder=|src1| before fix-up. Result: HI=src1; LO=0xFFFFFFFF (divu, or div with src1>=0); LO=1 (div with src1<0).
  - Overflow: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- DONE:
  - md_done=1 for exactly one cycle, coinciding with the HI/LO update.
  - md_ready=0 during DONE, 1 again the next cycle (back in IDLE).
- mthi/mtlo:
  - Honoured only while md_ready=1: HI and/or LO <= mt_wdata at the next edge.
  - mt_we asserted while busy is ignored; HI/LO are not corrupted.
  - If mt_we and an accepted request occur in the same cycle, the mt write happens and the later result overwrites.
- md_flush:
  - In MUL/DIV/DONE: next edge returns to IDLE, with no HI/LO write and no md_done.
  - A flush in the same cycle as the DONE write suppresses the write.
  - In IDLE, flush blocks acceptance that cycle.
- hi_rdata/lo_rdata are the registers directly; there is no bypass of in-flight or same-cycle writes.

Test Plan:
- After reset, mult 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA on 2nd edge; md_done pulses once; md_ready low for 2 cycles.
- multu 0xFFFFFFFF × 0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- div -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF, exactly 33 edges after accept; divu 100 / 7 → LO=14, HI=2.
- Division boundaries:
  - divu 5 / 0 → HI=5, LO=0xFFFFFFFF.
  - div -5 / 0 → HI=0xFFFFFFFB, LO=1.
  - div 0x80000000 / -1 → LO=0x80000000, HI=0.
- mthi 0x1234 in IDLE → HI=0x1234 next edge. mtlo during an active div is ignored; the final LO is the quotient.
- Start div 100/7, flush at iteration 10 → IDLE next cycle, HI/LO keep prior values, no md_done. Reset mid-div → HI=LO=0, md_ready=1.

Source files
------------

// File: rtl/es_hilo_muldiv.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Multiply takes one cycle in MUL. Restoring divide produces one quotient bit per cycle.
module es_hilo_muldiv #(
   parameter int DIV_CYCLES = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        md_valid,
   input  logic [3:0]  md_op,
   input  logic [31:0] md_src1,
   input  logic [31:0] md_src2,
   input  logic        md_flush,
   input  logic [1:0]  mt_we,
   input  logic [31:0] mt_wdata,
   output logic        md_ready,
   output logic        md_done,
   output logic [31:0] hi_rdata,
   output logic [31:0] lo_rdata
);

   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state, state_nxt;
   logic [31:0] hi, lo;
   logic [31:0] op_a, op_b;
   logic [63:0] acc;
   logic [5:0]  cnt;
   logic        is_mul, is_signed, sign1, sign2;

   logic        accept, mul_op, signed_op, neg1, neg2;
   logic [31:0] abs1, abs2;
   logic [63:0] ext_a, ext_b, prod;
   logic [32:0] rem_sh;
   logic        ge;
   logic [31:0] sub, r_nxt, quo_fix, rem_fix;

   assign mul_op    = md_op[0] | md_op[1];
   assign signed_op = md_op[0] | md_op[2];
   assign neg1      = signed_op & md_src1[31];
   assign neg2      = signed_op & md_src2[31];
   assign abs1      = neg1 ? -md_src1 : md_src1;
   assign abs2      = neg2 ? -md_src2 : md_src2;
   assign accept    = md_valid & (state == IDLE) & ~md_flush & $onehot(md_op);

   // Low 64 bits of the sign-extended product are correct for both mult and multu
   assign ext_a = {{32{is_signed & op_a[31]}}, op_a};
   assign ext_b = {{32{is_signed & op_b[31]}}, op_b};
   assign prod  = ext_a * ext_b;

   // acc = {partial remainder, dividend/quotient shift register}
   assign rem_sh = {acc[63:32], acc[31]};
   assign ge     = rem_sh >= {1'b0, op_b};
   assign sub    = rem_sh[31:0] - op_b;
   assign r_nxt  = ge ? sub : rem_sh[31:0];

   assign quo_fix = (sign1 ^ sign2) ? -acc[31:0] : acc[31:0];
   assign rem_fix = sign1 ? -acc[63:32] : acc[63:32];

   always_comb begin
      state_nxt = state;
      md_ready  = 1'b0;
      md_done   = 1'b0;
      case (state)
         IDLE: begin
            md_ready = 1'b1;
            if (accept) state_nxt = mul_op ? MUL : DIV;
         end
         MUL:  state_nxt = DONE;
         DIV:  if (cnt == 6'(DIV_CYCLES - 1)) state_nxt = DONE;
         DONE: begin
            md_done   = ~md_flush & ~reset;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
      if (md_flush && state != IDLE) state_nxt = IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         hi        <= '0;
         lo        <= '0;
         cnt       <= '0;
         acc       <= '0;
         op_a      <= '0;
         op_b      <= '0;
         is_mul    <= 1'b0;
         is_signed <= 1'b0;
         sign1     <= 1'b0;
         sign2     <= 1'b0;
      end else begin
         if (accept) begin
            op_a      <= md_src1;
            op_b      <= mul_op ? md_src2 : abs2;
            acc       <= {32'd0, abs1};
            is_mul    <= mul_op;
            is_signed <= signed_op;
            sign1     <= neg1;
            sign2     <= neg2;
            cnt       <= '0;
         end
         case (state)
            IDLE: begin
               if (mt_we[1]) hi <= mt_wdata;
               if (mt_we[0]) lo <= mt_wdata;
            end
            MUL: acc <= prod;
            DIV: begin
               acc <= {r_nxt, acc[30:0], ge};
               cnt <= cnt + 6'd1;
            end
            DONE: begin
               if (!md_flush) begin
                  if (is_mul) begin
                     hi <= acc[63:32];
                     lo <= acc[31:0];
                  end else begin
                     hi <= rem_fix;
                     lo <= quo_fix;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign hi_rdata = hi;
   assign lo_rdata = lo;

endmodule

// File: tb/tb_es_hilo_muldiv.sv
// Scoreboard bench for es_hilo_muldiv: expected HI/LO pushed at issue, popped at the write edge.
module tb_es_hilo_muldiv;

   logic        clk = 1'b0;
   logic        reset, md_valid, md_flush, md_ready, md_done;
   logic [3:0]  md_op;
   logic [31:0] md_src1, md_src2, mt_wdata, hi_rdata, lo_rdata;
   logic [1:0]  mt_we;

   int          checks = 0;
   int          errors = 0;
   logic [63:0] sb[$];
   logic [31:0] cur_hi = '0, cur_lo = '0;

   es_hilo_muldiv #(.DIV_CYCLES(32)) dut (
      .clk(clk), .reset(reset), .md_valid(md_valid), .md_op(md_op),
      .md_src1(md_src1), .md_src2(md_src2), .md_flush(md_flush),
      .mt_we(mt_we), .mt_wdata(mt_wdata), .md_ready(md_ready),
      .md_done(md_done), .hi_rdata(hi_rdata), .lo_rdata(lo_rdata)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa, sbb;
      logic signed [31:0] q, r;
      case (op)
         4'b0001: begin
            sa = $signed(a); sbb = $signed(b);
            return sa * sbb;
         end
         4'b0010: return {32'd0, a} * {32'd0, b};
         4'b0100: begin
            if (b == 0) return {a, (a[31] ? 32'd1 : 32'hFFFF_FFFF)};
            if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
            return {r, q};
         end
         default: begin
            if (b == 0) return {a, 32'hFFFF_FFFF};
            return {a % b, a / b};
         end
      endcase
   endfunction

   // Issue one op, optionally pulse mt_we at busy cycle mt_cyc, then check the result write.
   task automatic run_op(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int mt_cyc);
      int i, lat, ready_hi, hold_err;
      bit seen;
      logic [63:0] exp;
      sb.push_back(model(op, a, b));
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = op; md_src1 = a; md_src2 = b;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = '0;
      lat = (op[0] | op[1]) ? 2 : 33;
      i = 0; seen = 0; ready_hi = 0; hold_err = 0;
      while (!seen && i < 100) begin
         @(negedge clk);
         if (md_ready) ready_hi++;
         if (hi_rdata !== cur_hi || lo_rdata !== cur_lo) hold_err++;
         if (i == mt_cyc) begin mt_we = 2'b11; mt_wdata = 32'hDEAD_BEEF; end
         else mt_we = 2'b00;
         if (md_done) seen = 1;
         else i++;
      end
      mt_we = 2'b00;
      checks++;
      if (!seen) begin
         errors++;
         $display("FAIL %s timeout: md_done never seen", name);
         void'(sb.pop_front());
         return;
      end
      checks++;
      if (i + 1 != lat) begin
         errors++; $display("FAIL %s latency got %0d want %0d", name, i + 1, lat);
      end
      checks++;
      if (ready_hi != 0) begin
         errors++; $display("FAIL %s md_ready high %0d busy cycles want 0", name, ready_hi);
      end
      checks++;
      if (hold_err != 0) begin
         errors++; $display("FAIL %s hi/lo changed while busy %0d cycles want 0", name, hold_err);
      end
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({hi_rdata, lo_rdata} !== exp) begin
         errors++;
         $display("FAIL %s hi/lo got %h_%h want %h_%h", name, hi_rdata, lo_rdata, exp[63:32], exp[31:0]);
      end
      checks++;
      if (md_done !== 1'b0 || md_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after write done=%b ready=%b want 0 1", name, md_done, md_ready);
      end
      cur_hi = exp[63:32]; cur_lo = exp[31:0];
   endtask

   task automatic test_reset();
      reset = 1'b1; md_valid = 1'b0; md_op = '0; md_src1 = '0; md_src2 = '0;
      md_flush = 1'b0; mt_we = '0; mt_wdata = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      checks++;
      if (md_ready !== 1'b1 || md_done !== 1'b0 || hi_rdata !== 0 || lo_rdata !== 0) begin
         errors++;
         $display("FAIL reset ready=%b done=%b hi=%h lo=%h want 1 0 0 0", md_ready, md_done, hi_rdata, lo_rdata);
      end
      cur_hi = '0; cur_lo = '0;
   endtask

   task automatic test_mul();
      run_op("mult_neg2x3", 4'b0001, 32'hFFFF_FFFE, 32'd3, -1);
      checks++;
      if (hi_rdata !== 32'hFFFF_FFFF || lo_rdata !== 32'hFFFF_FFFA) begin
         errors++; $display("FAIL mult_const got %h_%h want ffffffff_fffffffa", hi_rdata, lo_rdata);
      end
      run_op("multu_max", 4'b0010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1);
      checks++;
      if (hi_rdata !== 32'hFFFF_FFFE || lo_rdata !== 32'h0000_0001) begin
         errors++; $display("FAIL multu_const got %h_%h want fffffffe_00000001", hi_rdata, lo_rdata);
      end
   endtask

   task automatic test_div();
      run_op("div_m7_2", 4'b0100, -32'sd7, 32'd2, -1);
      checks++;
      if (hi_rdata !== 32'hFFFF_FFFF || lo_rdata !== 32'hFFFF_FFFD) begin
         errors++; $display("FAIL div_const got %h_%h want ffffffff_fffffffd", hi_rdata, lo_rdata);
      end
      run_op("divu_100_7", 4'b1000, 32'd100, 32'd7, -1);
      run_op("divu_5_0",   4'b1000, 32'd5, 32'd0, -1);
      run_op("div_m5_0",   4'b0100, -32'sd5, 32'd0, -1);
      checks++;
      if (hi_rdata !== 32'hFFFF_FFFB || lo_rdata !== 32'd1) begin
         errors++; $display("FAIL div0_const got %h_%h want fffffffb_00000001", hi_rdata, lo_rdata);
      end
      run_op("div_ovf",    4'b0100, 32'h8000_0000, 32'hFFFF_FFFF, -1);
      run_op("div_7_m2",   4'b0100, 32'd7, -32'sd2, -1);
   endtask

   task automatic test_random();
      logic [3:0] ops [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
      for (int k = 0; k < 8; k++) begin
         logic [31:0] a, b;
         a = $urandom;
         b = (k % 2) ? $urandom_range(1, 300) : $urandom;
         run_op("random", ops[k % 4], a, b, -1);
      end
   endtask

   task automatic test_mt();
      @(posedge clk); #1 mt_we = 2'b10; mt_wdata = 32'h0000_1234;
      @(posedge clk); #1 mt_we = 2'b00;
      checks++;
      if (hi_rdata !== 32'h1234 || lo_rdata !== cur_lo) begin
         errors++; $display("FAIL mthi got %h_%h want 00001234_%h", hi_rdata, lo_rdata, cur_lo);
      end
      cur_hi = 32'h1234;
      @(posedge clk); #1 mt_we = 2'b01; mt_wdata = 32'h0000_5678;
      @(posedge clk); #1 mt_we = 2'b00;
      checks++;
      if (hi_rdata !== cur_hi || lo_rdata !== 32'h5678) begin
         errors++; $display("FAIL mtlo got %h_%h want %h_00005678", hi_rdata, lo_rdata, cur_hi);
      end
      cur_lo = 32'h5678;
      run_op("mt_during_div", 4'b1000, 32'd100, 32'd7, 5);
   endtask

   task automatic test_same_cycle_mt();
      int i;
      logic [63:0] exp;
      sb.push_back(model(4'b0001, 32'd5, 32'd7));
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 4'b0001; md_src1 = 32'd5; md_src2 = 32'd7;
      mt_we = 2'b11; mt_wdata = 32'hAAAA_5555;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = '0; mt_we = 2'b00;
      @(negedge clk);
      checks++;
      if (hi_rdata !== 32'hAAAA_5555 || lo_rdata !== 32'hAAAA_5555) begin
         errors++; $display("FAIL same_cycle_mt got %h_%h want aaaa5555_aaaa5555", hi_rdata, lo_rdata);
      end
      i = 0;
      while (!md_done && i < 10) begin @(negedge clk); i++; end
      @(posedge clk); #1;
      exp = sb.pop_front();
      checks++;
      if ({hi_rdata, lo_rdata} !== exp) begin
         errors++; $display("FAIL same_cycle_result got %h_%h want %h", hi_rdata, lo_rdata, exp);
      end
      cur_hi = exp[63:32]; cur_lo = exp[31:0];
   endtask

   task automatic test_flush();
      int dones, changed;
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 4'b1000; md_src1 = 32'd100; md_src2 = 32'd7;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = '0;
      repeat (10) @(posedge clk);
      #1 md_flush = 1'b1;
      @(posedge clk); #1 md_flush = 1'b0;
      checks++;
      if (md_ready !== 1'b1 || hi_rdata !== cur_hi || lo_rdata !== cur_lo) begin
         errors++;
         $display("FAIL flush_div ready=%b hi=%h lo=%h want 1 %h %h", md_ready, hi_rdata, lo_rdata, cur_hi, cur_lo);
      end
      dones = 0; changed = 0;
      repeat (40) begin
         @(negedge clk);
         if (md_done) dones++;
         if (hi_rdata !== cur_hi || lo_rdata !== cur_lo) changed++;
      end
      checks++;
      if (dones != 0 || changed != 0) begin
         errors++; $display("FAIL flush_quiet dones=%0d changed=%0d want 0 0", dones, changed);
      end
      // Flush landing in the DONE cycle must suppress the write and the pulse.
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 4'b0010; md_src1 = 32'd9; md_src2 = 32'd9;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = '0;
      @(posedge clk); #1 md_flush = 1'b1;
      #1;
      checks++;
      if (md_done !== 1'b0) begin
         errors++; $display("FAIL flush_done_pulse got %b want 0", md_done);
      end
      @(posedge clk); #1 md_flush = 1'b0;
      checks++;
      if (md_ready !== 1'b1 || hi_rdata !== cur_hi || lo_rdata !== cur_lo) begin
         errors++;
         $display("FAIL flush_done ready=%b hi=%h lo=%h want 1 %h %h", md_ready, hi_rdata, lo_rdata, cur_hi, cur_lo);
      end
   endtask

   task automatic test_idle_blocks();
      int bad;
      logic [3:0] bad_ops [4] = '{4'b0000, 4'b0011, 4'b1100, 4'b1111};
      for (int k = 0; k < 5; k++) begin
         @(posedge clk); #1;
         md_valid = 1'b1; md_src1 = 32'd3; md_src2 = 32'd4;
         if (k < 4) md_op = bad_ops[k];
         else begin md_op = 4'b0001; md_flush = 1'b1; end
         @(posedge clk); #1;
         md_valid = 1'b0; md_op = '0; md_flush = 1'b0;
         bad = 0;
         repeat (3) begin
            @(negedge clk);
            if (md_ready !== 1'b1 || md_done !== 1'b0) bad++;
         end
         checks++;
         if (bad != 0 || hi_rdata !== cur_hi || lo_rdata !== cur_lo) begin
            errors++; $display("FAIL no_accept case %0d bad=%0d hi=%h lo=%h", k, bad, hi_rdata, lo_rdata);
         end
      end
   endtask

   task automatic test_back_to_back();
      run_op("b2b_mult", 4'b0001, 32'h7FFF_FFFF, 32'h7FFF_FFFF, -1);
      run_op("b2b_div",  4'b0100, 32'h8000_0000, 32'd3, -1);
      run_op("b2b_mult2", 4'b0001, 32'h8000_0000, 32'hFFFF_FFFF, -1);
   endtask

   task automatic test_reset_mid();
      int dones;
      @(posedge clk); #1;
      md_valid = 1'b1; md_op = 4'b0100; md_src1 = 32'd1000; md_src2 = 32'd9;
      @(posedge clk); #1;
      md_valid = 1'b0; md_op = '0;
      repeat (15) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk); #1 reset = 1'b0;
      checks++;
      if (md_ready !== 1'b1 || hi_rdata !== 0 || lo_rdata !== 0 || md_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_mid ready=%b done=%b hi=%h lo=%h want 1 0 0 0", md_ready, md_done, hi_rdata, lo_rdata);
      end
      cur_hi = '0; cur_lo = '0;
      dones = 0;
      repeat (40) begin @(negedge clk); if (md_done) dones++; end
      checks++;
      if (dones != 0) begin
         errors++; $display("FAIL reset_mid_done got %0d pulses want 0", dones);
      end
   endtask

   initial begin
      test_reset();
      test_mul();
      test_div();
      test_mt();
      test_same_cycle_mt();
      test_flush();
      test_idle_blocks();
      test_back_to_back();
      test_random();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
